// File: rtl/adc_poll_pkg.sv
// rtl/adc_poll_pkg.sv - shared types and constants for the ADC poll scheduler
package adc_poll_pkg;

  localparam int CODE_W = 12;

  localparam logic [CODE_W-1:0] TEMP_HI_DEF = 12'hCC2;
  localparam logic [CODE_W-1:0] TEMP_LO_DEF = 12'hA5B;
  localparam logic [CODE_W-1:0] VOLT_HI_DEF = 12'h59A;
  localparam logic [CODE_W-1:0] VOLT_LO_DEF = 12'h511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_T,
    ST_SET_T,
    ST_CAP_T,
    ST_REQ_V,
    ST_SET_V,
    ST_CAP_V
  } state_e;

endpackage

// File: rtl/adc_poll_avg.sv
// rtl/adc_poll_avg.sv - per-channel sample accumulator and power-of-two averager
module adc_poll_avg
  import adc_poll_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic [CODE_W-1:0] sample,
  output logic              done,
  output logic [CODE_W-1:0] avg
);

  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The final sample is folded in combinationally so the average is ready at the capture edge.
  always_comb begin
    sum   = acc_q + ACC_W'(sample);
    done  = cap && (cnt_q == CNT_LAST);
    avg   = CODE_W'(sum >> AVG_LOG2);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr || done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (cap) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_poll_sched.sv
// rtl/adc_poll_sched.sv - periodic temp/VCC poll scheduler with averaging and alarms; ADC_POLL_MINMAX_EN adds min/max tracking
module adc_poll_sched
  import adc_poll_pkg::*;
#(
  parameter int                POLL_DIV   = 50000,
  parameter int                REQ_HOLD   = 4,
  parameter int                SETTLE_CYC = 64,
  parameter int                CODE_MSB   = 15,
  parameter int                AVG_LOG2   = 2,
  parameter logic [CODE_W-1:0] TEMP_HI    = TEMP_HI_DEF,
  parameter logic [CODE_W-1:0] TEMP_LO    = TEMP_LO_DEF,
  parameter logic [CODE_W-1:0] VOLT_HI    = VOLT_HI_DEF,
  parameter logic [CODE_W-1:0] VOLT_LO    = VOLT_LO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       pdata,
  output logic              dbg_temp_rd,
  output logic              dbg_volt_rd,
  output logic [CODE_W-1:0] temp_code,
  output logic [CODE_W-1:0] volt_code,
  output logic              temp_valid,
  output logic              volt_valid,
  output logic              temp_alarm,
  output logic              volt_alarm,
  output logic              busy,
  output logic              tick_miss
`ifdef ADC_POLL_MINMAX_EN
  ,
  input  logic              minmax_clr,
  output logic [CODE_W-1:0] temp_min,
  output logic [CODE_W-1:0] temp_max,
  output logic [CODE_W-1:0] volt_min,
  output logic [CODE_W-1:0] volt_max
`endif
);

  localparam int TCNT_W = $clog2(POLL_DIV + 1);
  localparam int PH_MAX = (REQ_HOLD > SETTLE_CYC) ? REQ_HOLD : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(POLL_DIV - 1);
  localparam logic [PH_W-1:0]   REQ_LAST  = PH_W'(REQ_HOLD - 1);
  localparam logic [PH_W-1:0]   SET_LAST  = PH_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                tick_q, tick_d;
  logic                temp_rd_q, temp_rd_d, volt_rd_q, volt_rd_d;
  logic                busy_q, busy_d, tick_miss_q, tick_miss_d;
  logic [CODE_W-1:0]   temp_code_q, temp_code_d, volt_code_q, volt_code_d;
  logic                temp_valid_q, temp_valid_d, volt_valid_q, volt_valid_d;
  logic                temp_alarm_q, temp_alarm_d, volt_alarm_q, volt_alarm_d;
  logic                cap_t, cap_v, temp_done, volt_done;
  logic [CODE_W-1:0]   sample, temp_avg, volt_avg;
  logic                unused_pdata;

  assign sample       = pdata[CODE_MSB -: CODE_W];
  assign unused_pdata = ^pdata;

  adc_poll_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_temp (
    .clk(clk), .rst_n(rst_n), .clr(!enable), .cap(cap_t),
    .sample(sample), .done(temp_done), .avg(temp_avg)
  );

  adc_poll_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_volt (
    .clk(clk), .rst_n(rst_n), .clr(!enable), .cap(cap_v),
    .sample(sample), .done(volt_done), .avg(volt_avg)
  );

  always_comb begin
    tcnt_d      = (!enable || tcnt_q == TCNT_LAST) ? '0 : tcnt_q + TCNT_W'(1);
    tick_d      = enable && (tcnt_q == TCNT_LAST);
    tick_miss_d = tick_q && (state_q != ST_IDLE);
    state_d     = state_q;
    ph_d        = ph_q;
    cap_t       = 1'b0;
    cap_v       = 1'b0;
    // Capture happens on the edge that leaves the settle window, so the code lands one cycle before CAP ends.
    if (!enable) begin
      state_d = ST_IDLE;
      ph_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (tick_q) begin state_d = ST_REQ_T; ph_d = '0; end
        ST_REQ_T: if (ph_q == REQ_LAST) begin state_d = ST_SET_T; ph_d = '0; end
                  else ph_d = ph_q + PH_W'(1);
        ST_SET_T: if (ph_q == SET_LAST) begin state_d = ST_CAP_T; ph_d = '0; cap_t = 1'b1; end
                  else ph_d = ph_q + PH_W'(1);
        ST_CAP_T: state_d = ST_REQ_V;
        ST_REQ_V: if (ph_q == REQ_LAST) begin state_d = ST_SET_V; ph_d = '0; end
                  else ph_d = ph_q + PH_W'(1);
        ST_SET_V: if (ph_q == SET_LAST) begin state_d = ST_CAP_V; ph_d = '0; cap_v = 1'b1; end
                  else ph_d = ph_q + PH_W'(1);
        ST_CAP_V: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    temp_rd_d    = (state_d == ST_REQ_T);
    volt_rd_d    = (state_d == ST_REQ_V);
    busy_d       = (state_d != ST_IDLE);
    temp_valid_d = temp_done;
    volt_valid_d = volt_done;
    temp_code_d  = temp_done ? temp_avg : temp_code_q;
    volt_code_d  = volt_done ? volt_avg : volt_code_q;
    temp_alarm_d = temp_alarm_q;
    if (temp_done) begin
      if (temp_avg > TEMP_HI)      temp_alarm_d = 1'b1;
      else if (temp_avg < TEMP_LO) temp_alarm_d = 1'b0;
    end
    volt_alarm_d = volt_done ? ((volt_avg > VOLT_HI) | (volt_avg < VOLT_LO)) : volt_alarm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      ph_q         <= '0;
      tick_q       <= 1'b0;
      tick_miss_q  <= 1'b0;
      temp_rd_q    <= 1'b0;
      volt_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      temp_valid_q <= 1'b0;
      volt_valid_q <= 1'b0;
      temp_code_q  <= '0;
      volt_code_q  <= '0;
      temp_alarm_q <= 1'b0;
      volt_alarm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      ph_q         <= ph_d;
      tick_q       <= tick_d;
      tick_miss_q  <= tick_miss_d;
      temp_rd_q    <= temp_rd_d;
      volt_rd_q    <= volt_rd_d;
      busy_q       <= busy_d;
      temp_valid_q <= temp_valid_d;
      volt_valid_q <= volt_valid_d;
      temp_code_q  <= temp_code_d;
      volt_code_q  <= volt_code_d;
      temp_alarm_q <= temp_alarm_d;
      volt_alarm_q <= volt_alarm_d;
    end
  end

  assign dbg_temp_rd = temp_rd_q;
  assign dbg_volt_rd = volt_rd_q;
  assign temp_code   = temp_code_q;
  assign volt_code   = volt_code_q;
  assign temp_valid  = temp_valid_q;
  assign volt_valid  = volt_valid_q;
  assign temp_alarm  = temp_alarm_q;
  assign volt_alarm  = volt_alarm_q;
  assign busy        = busy_q;
  assign tick_miss   = tick_miss_q;

`ifdef ADC_POLL_MINMAX_EN
  logic [CODE_W-1:0] temp_min_q, temp_min_d, temp_max_q, temp_max_d;
  logic [CODE_W-1:0] volt_min_q, volt_min_d, volt_max_q, volt_max_d;

  // A clear coinciding with a new code restarts tracking from that code.
  always_comb begin
    temp_min_d = minmax_clr ? {CODE_W{1'b1}} : temp_min_q;
    temp_max_d = minmax_clr ? {CODE_W{1'b0}} : temp_max_q;
    volt_min_d = minmax_clr ? {CODE_W{1'b1}} : volt_min_q;
    volt_max_d = minmax_clr ? {CODE_W{1'b0}} : volt_max_q;
    if (temp_done) begin
      if (temp_avg < temp_min_d) temp_min_d = temp_avg;
      if (temp_avg > temp_max_d) temp_max_d = temp_avg;
    end
    if (volt_done) begin
      if (volt_avg < volt_min_d) volt_min_d = volt_avg;
      if (volt_avg > volt_max_d) volt_max_d = volt_avg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_min_q <= {CODE_W{1'b1}};
      temp_max_q <= {CODE_W{1'b0}};
      volt_min_q <= {CODE_W{1'b1}};
      volt_max_q <= {CODE_W{1'b0}};
    end else begin
      temp_min_q <= temp_min_d;
      temp_max_q <= temp_max_d;
      volt_min_q <= volt_min_d;
      volt_max_q <= volt_max_d;
    end
  end

  assign temp_min = temp_min_q;
  assign temp_max = temp_max_q;
  assign volt_min = volt_min_q;
  assign volt_max = volt_max_q;
`endif

endmodule

// File: tb/tb_adc_poll_sched.sv
// tb/tb_adc_poll_sched.sv - self-checking bench: round-position model plus directed literal checks
module tb_adc_poll_sched;

  localparam int H  = 4;
  localparam int S  = 16;
  localparam int RL = 2 * (H + S + 1);
  localparam int PD [2] = '{200, 30};
  localparam int AL [2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = 2'b00;
  logic [15:0] pd [2];
  logic [1:0]  trd, vrd, tval, vval, talm, valm, busy, miss;
  logic [11:0] tcode [2];
  logic [11:0] vcode [2];

  logic [11:0] TT [2][8] = '{'{12'hA00, 12'hA00, 12'hCD0, 12'hB00, 12'hA00, 12'hC00, 12'hC00, 12'hC00},
                             '{12'h100, 12'h101, 12'h102, 12'h104, 12'h200, 12'h200, 12'h200, 12'h200}};
  logic [11:0] VT [2][8] = '{'{12'h540, 12'h540, 12'h5A0, 12'h540, 12'h500, 12'h5FF, 12'h5FF, 12'h5FF},
                             '{12'h540, 12'h541, 12'h542, 12'h543, 12'h550, 12'h550, 12'h550, 12'h550}};
  logic [11:0] ET [5]  = '{12'hA00, 12'hA00, 12'hCD0, 12'hB00, 12'hA00};
  logic [11:0] EV [5]  = '{12'h540, 12'h540, 12'h5A0, 12'h540, 12'h500};
  int          ETA [5] = '{0, 0, 1, 1, 0};
  int          EVA [5] = '{0, 0, 1, 0, 1};

  int checks = 0;
  int errors = 0;
  int b_tval_cnt = 0;
  int b_miss_cnt = 0;

  always #5 clk = ~clk;

  adc_poll_sched #(.POLL_DIV(200), .REQ_HOLD(H), .SETTLE_CYC(S), .CODE_MSB(15), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .pdata(pd[0]),
    .dbg_temp_rd(trd[0]), .dbg_volt_rd(vrd[0]), .temp_code(tcode[0]), .volt_code(vcode[0]),
    .temp_valid(tval[0]), .volt_valid(vval[0]), .temp_alarm(talm[0]), .volt_alarm(valm[0]),
    .busy(busy[0]), .tick_miss(miss[0]));

  adc_poll_sched #(.POLL_DIV(30), .REQ_HOLD(H), .SETTLE_CYC(S), .CODE_MSB(15), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .pdata(pd[1]),
    .dbg_temp_rd(trd[1]), .dbg_volt_rd(vrd[1]), .temp_code(tcode[1]), .volt_code(vcode[1]),
    .temp_valid(tval[1]), .volt_valid(vval[1]), .temp_alarm(talm[1]), .volt_alarm(valm[1]),
    .busy(busy[1]), .tick_miss(miss[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: round position counted from round start (-1 when idle), samples averaged as plain integers.
  int m_tcnt [2] = '{0, 0};
  int m_tick [2] = '{0, 0};
  int m_pos  [2] = '{-1, -1};
  int m_rnd  [2] = '{0, 0};
  int m_ridx [2] = '{0, 0};
  int m_tacc [2] = '{0, 0};
  int m_tn   [2] = '{0, 0};
  int m_vacc [2] = '{0, 0};
  int m_vn   [2] = '{0, 0};
  int m_tcode[2] = '{0, 0};
  int m_vcode[2] = '{0, 0};
  int m_tval [2] = '{0, 0};
  int m_vval [2] = '{0, 0};
  int m_talm [2] = '{0, 0};
  int m_valm [2] = '{0, 0};
  int m_miss [2] = '{0, 0};
  int old_pos, tk_prev, smp, idx;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_tcnt[i] = 0; m_tick[i] = 0; m_pos[i] = -1; m_rnd[i] = 0; m_ridx[i] = 0;
        m_tacc[i] = 0; m_tn[i] = 0; m_vacc[i] = 0; m_vn[i] = 0;
        m_tcode[i] = 0; m_vcode[i] = 0; m_tval[i] = 0; m_vval[i] = 0;
        m_talm[i] = 0; m_valm[i] = 0; m_miss[i] = 0;
      end else begin
        tk_prev = m_tick[i];
        old_pos = m_pos[i];
        smp = int'(pd[i][15:4]);
        m_tick[i] = (en[i] && m_tcnt[i] == PD[i] - 1) ? 1 : 0;
        m_tcnt[i] = (!en[i] || m_tcnt[i] == PD[i] - 1) ? 0 : m_tcnt[i] + 1;
        m_miss[i] = (tk_prev != 0 && old_pos >= 0) ? 1 : 0;
        m_tval[i] = 0;
        m_vval[i] = 0;
        if (!en[i]) begin
          m_pos[i] = -1;
          m_tacc[i] = 0; m_tn[i] = 0; m_vacc[i] = 0; m_vn[i] = 0;
        end else if (old_pos < 0) begin
          if (tk_prev != 0) begin
            m_pos[i] = 0;
            m_ridx[i] = m_rnd[i];
            m_rnd[i]++;
          end
        end else begin
          m_pos[i] = (old_pos + 1 == RL) ? -1 : old_pos + 1;
        end
        if (m_pos[i] == H + S) begin
          m_tacc[i] += smp;
          m_tn[i]++;
          if (m_tn[i] == (1 << AL[i])) begin
            m_tcode[i] = m_tacc[i] / (1 << AL[i]);
            m_tval[i] = 1;
            if (m_tcode[i] > 'hCC2) m_talm[i] = 1;
            else if (m_tcode[i] < 'hA5B) m_talm[i] = 0;
            m_tacc[i] = 0; m_tn[i] = 0;
          end
        end
        if (m_pos[i] == 2 * H + 2 * S + 1) begin
          m_vacc[i] += smp;
          m_vn[i]++;
          if (m_vn[i] == (1 << AL[i])) begin
            m_vcode[i] = m_vacc[i] / (1 << AL[i]);
            m_vval[i] = 1;
            m_valm[i] = (m_vcode[i] > 'h59A || m_vcode[i] < 'h511) ? 1 : 0;
            m_vacc[i] = 0; m_vn[i] = 0;
          end
        end
      end
    end
    #2;
    // pdata carries the matching channel only during its settle window, noise elsewhere.
    for (int i = 0; i < 2; i++) begin
      idx = m_ridx[i] % 8;
      if (m_pos[i] >= H + 1 && m_pos[i] <= H + S)
        pd[i] = {TT[i][idx], 4'($urandom)};
      else if (m_pos[i] >= 2 * H + S + 2 && m_pos[i] <= 2 * H + 2 * S + 1)
        pd[i] = {VT[i][idx], 4'($urandom)};
      else
        pd[i] = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d.dbg_temp_rd", i), int'(trd[i]), (m_pos[i] >= 0 && m_pos[i] < H) ? 1 : 0);
      chk($sformatf("dut%0d.dbg_volt_rd", i), int'(vrd[i]),
          (m_pos[i] >= H + S + 1 && m_pos[i] < 2 * H + S + 1) ? 1 : 0);
      chk($sformatf("dut%0d.busy", i), int'(busy[i]), (m_pos[i] >= 0) ? 1 : 0);
      chk($sformatf("dut%0d.tick_miss", i), int'(miss[i]), m_miss[i]);
      chk($sformatf("dut%0d.temp_valid", i), int'(tval[i]), m_tval[i]);
      chk($sformatf("dut%0d.volt_valid", i), int'(vval[i]), m_vval[i]);
      chk($sformatf("dut%0d.temp_code", i), int'(tcode[i]), m_tcode[i]);
      chk($sformatf("dut%0d.volt_code", i), int'(vcode[i]), m_vcode[i]);
      chk($sformatf("dut%0d.temp_alarm", i), int'(talm[i]), m_talm[i]);
      chk($sformatf("dut%0d.volt_alarm", i), int'(valm[i]), m_valm[i]);
    end
    chk("req_overlap", int'(|(trd & vrd)), 0);
    if (tval[1]) b_tval_cnt++;
    if (miss[1]) b_miss_cnt++;
  end

  int n;

  initial begin
    pd[0] = 16'h0;
    pd[1] = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dut%0d.temp_code", i), int'(tcode[i]), 0);
      chk($sformatf("reset dut%0d.busy", i), int'(busy[i]), 0);
      chk($sformatf("reset dut%0d.alarms", i), int'({talm[i], valm[i]}), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    en[0] = 1'b1;

    // Basic capture, hysteresis and voltage window on the unaveraged instance.
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (!vval[0] && n < 400) begin @(negedge clk); n++; end
      chk($sformatf("a round%0d volt_valid seen", r), int'(vval[0]), 1);
      chk($sformatf("a round%0d temp_code", r), int'(tcode[0]), int'(ET[r]));
      chk($sformatf("a round%0d volt_code", r), int'(vcode[0]), int'(EV[r]));
      chk($sformatf("a round%0d temp_alarm", r), int'(talm[0]), ETA[r]);
      chk($sformatf("a round%0d volt_alarm", r), int'(valm[0]), EVA[r]);
      @(negedge clk);
    end

    // Drop enable while the temperature settle window is running.
    n = 0;
    while (!trd[0] && n < 400) begin @(negedge clk); n++; end
    chk("a drop: temp request seen", int'(trd[0]), 1);
    n = 0;
    while (trd[0] && n < 20) begin @(negedge clk); n++; end
    chk("a drop: temp request fell", int'(trd[0]), 0);
    repeat (3) @(negedge clk);
    chk("a drop: busy before drop", int'(busy[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("a drop: busy", int'(busy[0]), 0);
    chk("a drop: requests", int'({trd[0], vrd[0]}), 0);
    chk("a drop: temp_code held", int'(tcode[0]), 'hA00);
    chk("a drop: volt_code held", int'(vcode[0]), 'h500);
    repeat (40) @(negedge clk);

    // Averaging over four rounds with ticks arriving faster than rounds complete.
    en[1] = 1'b1;
    n = 0;
    while (!tval[1] && n < 700) begin @(negedge clk); n++; end
    chk("b temp_valid seen", int'(tval[1]), 1);
    chk("b temp_code avg", int'(tcode[1]), 'h101);
    chk("b temp_alarm", int'(talm[1]), 0);
    n = 0;
    while (!vval[1] && n < 60) begin @(negedge clk); n++; end
    chk("b volt_valid seen", int'(vval[1]), 1);
    chk("b volt_code avg", int'(vcode[1]), 'h541);
    chk("b volt_alarm", int'(valm[1]), 0);
    chk("b single temp strobe", b_tval_cnt, 1);
    chk("b tick_miss seen", int'(b_miss_cnt > 0), 1);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
